// File: rtl/filtro_iir_seq.sv
// rtl/filtro_iir_seq.sv - sequential biquad IIR engine, one MAC per ROM coefficient
// Walks the coefficient ROM through b0,b1,b2,-a1,-a2 and saturates once on output.
module filtro_iir_seq #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [cant_bits-1:0] x_in,
  output logic [3:0]                  sel_cte,
  input  logic signed [cant_bits-1:0] cte,
  output logic signed [cant_bits-1:0] y_out,
  output logic                        done,
  output logic                        busy
);

  localparam int W  = cant_bits;
  localparam int PW = 2 * cant_bits;
  localparam int AW = 2 * cant_bits + 3;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_M4   = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [W-1:0]   x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  logic signed [W-1:0]   y1_q, y1_d, y2_q, y2_d;
  logic signed [W-1:0]   yo_q, yo_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [3:0]            sel_q, sel_d;

  logic signed [W-1:0]   op;
  logic signed [PW-1:0]  cte_ext, op_ext, prod;
  logic signed [AW-1:0]  prod_ext, shifted;
  logic signed [W-1:0]   r_sat;

  // Select is decoded from the next state so it is a clean register output.
  function automatic logic [3:0] sel_of(input state_t s);
    case (s)
      S_M0:    sel_of = 4'b0101;
      S_M1:    sel_of = 4'b0110;
      S_M2:    sel_of = 4'b0111;
      S_M3:    sel_of = 4'b0001;
      S_M4:    sel_of = 4'b0010;
      default: sel_of = 4'b0000;
    endcase
  endfunction

  always_comb begin
    op = '0;
    case (state_q)
      S_M0:    op = x0_q;
      S_M1:    op = x1_q;
      S_M2:    op = x2_q;
      S_M3:    op = y1_q;
      S_M4:    op = y2_q;
      default: op = '0;
    endcase
  end

  assign cte_ext  = {{W{cte[W-1]}}, cte};
  assign op_ext   = {{W{op[W-1]}}, op};
  assign prod     = cte_ext * op_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

  // Arithmetic shift floors toward -inf; clamp happens on the full-width value.
  assign shifted = acc_q >>> frac_bits;

  always_comb begin
    r_sat = shifted[W-1:0];
    if (shifted > SAT_MAX) begin
      r_sat = SAT_MAX[W-1:0];
    end else if (shifted < SAT_MIN) begin
      r_sat = SAT_MIN[W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    yo_d    = yo_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d    = x_in;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_M0;
        end
      end
      S_M0: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_M1;
      end
      S_M1: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_M2;
      end
      S_M2: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_M3;
      end
      S_M3: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_M4;
      end
      S_M4: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_OUT;
      end
      S_OUT: begin
        yo_d    = r_sat;
        x2_d    = x1_q;
        x1_d    = x0_q;
        y2_d    = y1_q;
        y1_d    = r_sat;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sel_d = sel_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      yo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      yo_q    <= yo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  assign sel_cte = sel_q;
  assign y_out   = yo_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_filtro_iir_seq.sv
// tb/tb_filtro_iir_seq.sv - bench for filtro_iir_seq with high-pass ROM model and scoreboard
module tb_filtro_iir_seq;

  localparam longint B0  = 16351;
  localparam longint B1  = -32702;
  localparam longint B2  = 16351;
  localparam longint NA1 = 32702;
  localparam longint NA2 = -16320;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [24:0] x_in = '0;
  logic [3:0]         sel_cte;
  logic signed [24:0] cte;
  logic signed [24:0] y_out;
  logic               done;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [24:0] exp_q[$];
  longint mx1, mx2, my1, my2;

  always #5 clk = ~clk;

  filtro_iir_seq #(.cant_bits(25), .frac_bits(14)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .sel_cte(sel_cte), .cte(cte), .y_out(y_out), .done(done), .busy(busy)
  );

  function automatic logic signed [24:0] rom(input logic [3:0] s);
    longint v;
    case (s)
      4'b0000: v = 16384;
      4'b0001: v = NA1;
      4'b0010: v = NA2;
      4'b0101: v = B0;
      4'b0110: v = B1;
      4'b0111: v = B2;
      default: v = 0;
    endcase
    return 25'(v);
  endfunction

  assign cte = rom(sel_cte);

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic signed [24:0] x);
    longint xs, acc, r;
    xs  = longint'(x);
    acc = B0 * xs + B1 * mx1 + B2 * mx2 + NA1 * my1 + NA2 * my2;
    r   = acc >>> 14;
    if (r > 64'sd16777215) r = 64'sd16777215;
    if (r < -64'sd16777216) r = -64'sd16777216;
    mx2 = mx1; mx1 = xs; my2 = my1; my1 = r;
    exp_q.push_back(25'(r));
  endtask

  // Scoreboard: every done pops one expected output.
  always @(negedge clk) begin
    if (!reset && done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done y_out=%h (no expected entry)", y_out);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if (y_out !== e) begin
          n_fail++;
          $display("FAIL sb_y_out got=%h exp=%h", y_out, e);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; start = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic wait_done(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout done=%b exp=1 within 20 cycles", name, done);
    end
  endtask

  task automatic run_sample(input logic signed [24:0] x, output logic [24:0] y);
    logic ok;
    start = 1'b1; x_in = x;
    model_push(x);
    @(posedge clk); #1 start = 1'b0;
    wait_done("run_sample", ok);
    y = y_out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [24:0] y;
    @(negedge clk);
    n_tests++;
    if ({done, busy, sel_cte, y_out} !== {1'b0, 1'b0, 4'b0000, 25'd0}) begin
      n_fail++;
      $display("FAIL reset_init got done=%b busy=%b sel=%b y=%h exp 0/0/0000/0", done, busy, sel_cte, y_out);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    run_sample(25'h0004000, y);
    start = 1'b1; x_in = 25'h0123456;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    n_tests++;
    if ({done, busy, sel_cte, y_out} !== {1'b0, 1'b0, 4'b0000, 25'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_m2 got done=%b busy=%b sel=%b y=%h exp 0/0/0000/0", done, busy, sel_cte, y_out);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done cycle=%0d got=%b exp=0", i, done);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sequence();
    logic [3:0] sel_exp[7];
    sel_exp = '{4'b0101, 4'b0110, 4'b0111, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
    do_reset();
    start = 1'b1; x_in = 25'h0004000;
    model_push(x_in);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_tests++;
      if (sel_cte !== sel_exp[i] || busy !== (i < 6) || done !== (i == 6)) begin
        n_fail++;
        $display("FAIL seq_cycle%0d got sel=%b busy=%b done=%b exp sel=%b busy=%b done=%b",
                 i + 1, sel_cte, busy, done, sel_exp[i], (i < 6), (i == 6));
      end
    end
    n_tests++;
    if (y_out !== 25'h0003FDF) begin
      n_fail++;
      $display("FAIL impulse_y0 got=%h exp=0003fdf", y_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    logic [24:0] y;
    run_sample(25'd0, y);
    n_tests++;
    if (y !== 25'h1FFFFBE) begin
      n_fail++;
      $display("FAIL impulse_y1 got=%h exp=1ffffbe", y);
    end
    for (int i = 2; i < 50; i++) run_sample(25'd0, y);
  endtask

  task automatic test_saturation();
    logic [24:0] y;
    do_reset();
    run_sample(25'h0FFFFFF, y);
    n_tests++;
    if (y !== 25'h0FF7BFF) begin n_fail++; $display("FAIL sat_neg_y0 got=%h exp=0ff7bff", y); end
    run_sample(25'h1000000, y);
    n_tests++;
    if (y !== 25'h1000000) begin n_fail++; $display("FAIL sat_neg_clamp got=%h exp=1000000", y); end
    do_reset();
    run_sample(25'h1000000, y);
    n_tests++;
    if (y !== 25'h1008400) begin n_fail++; $display("FAIL sat_pos_y0 got=%h exp=1008400", y); end
    run_sample(25'h0FFFFFF, y);
    n_tests++;
    if (y !== 25'h0FFFFFF) begin n_fail++; $display("FAIL sat_pos_clamp got=%h exp=0ffffff", y); end
  endtask

  task automatic test_busy_protection();
    logic [24:0] e;
    int ndone;
    logic [24:0] ylast;
    start = 1'b1; x_in = 25'h0001234;
    model_push(x_in);
    e = exp_q[exp_q.size() - 1];
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; x_in = 25'h0ABCDEF;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1; x_in = 25'h1555555;
    @(posedge clk); #1 start = 1'b0;
    ndone = 0; ylast = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; ylast = y_out; end
    end
    n_tests++;
    if (ndone != 1 || ylast !== e) begin
      n_fail++;
      $display("FAIL busy_ignore got dones=%0d y=%h exp dones=1 y=%h", ndone, ylast, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_recovery();
    logic [24:0] y;
    int ndone;
    for (int i = 0; i < 3; i++) run_sample(25'($urandom_range(0, 33554431)), y);
    start = 1'b1; x_in = 25'h0777777;
    model_push(x_in);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin n_fail++; $display("FAIL recov_discard got dones=%0d exp=0", ndone); end
    @(posedge clk); #1;
    run_sample(25'h0004000, y);
    n_tests++;
    if (y !== 25'h0003FDF) begin n_fail++; $display("FAIL recov_impulse got=%h exp=0003fdf", y); end
  endtask

  task automatic test_back_to_back();
    logic signed [24:0] vals[4];
    logic ok;
    time t_prev;
    vals = '{25'h0004000, 25'h1FF0000, 25'h0010000, 25'h0000123};
    t_prev = 0;
    start = 1'b1; x_in = vals[0];
    model_push(vals[0]);
    for (int k = 0; k < 4; k++) begin
      wait_done("b2b", ok);
      if (!ok) break;
      if (k > 0) begin
        n_tests++;
        if ($time - t_prev != 70) begin
          n_fail++;
          $display("FAIL b2b_period k=%0d got=%0t exp=70", k, $time - t_prev);
        end
      end
      t_prev = $time;
      if (k < 3) begin
        x_in = vals[k + 1];
        model_push(vals[k + 1]);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sequence();
    test_impulse();
    test_saturation();
    test_busy_protection();
    test_reset_recovery();
    test_back_to_back();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/filtro_iir_seq.md
# filtro_iir_seq

Sequential biquad IIR engine that reads the 25-bit high-pass coefficient set from the combinational coefficient ROM and filters one audio sample per `start` strobe. It drives the ROM's `sel_cte` select, accepts its `cte` word the same cycle, and runs one multiply-accumulate per coefficient. It keeps its own x/y delay lines and returns a saturated 25-bit output with a one-cycle `done` pulse. It sits between the sample-acquisition front end and the output formatter.

## Interface
- `cant_bits`, 25: word width of samples, coefficients and output (signed two's complement)
- `frac_bits`, 14: fractional bits of coefficients (0x4000 = 1.0)
- `clk`  input  1  system clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `start`  input  1  new-sample strobe, sampled only in IDLE
- `x_in`  input  cant_bits  input sample, captured on the accepted `start` edge
- `sel_cte`  output  4  coefficient select to ROM
- `cte`  input  cant_bits  coefficient from ROM (combinational, valid same cycle as `sel_cte`)
- `y_out`  output  cant_bits  filtered sample, registered, held until next `done`
- `done`  output  1  one-cycle pulse, `y_out` valid
- `busy`  output  1  high from accepted `start` until `done`

## Operation
- Equation: y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] + (−a1)·y[n-1] + (−a2)·y[n-2]. ROM stores −a1 and −a2 already negated; always add.
- FSM states: IDLE, M0, M1, M2, M3, M4, OUT.
- IDLE: `sel_cte`=0000. On `start`=1: capture `x_in` into x0, clear accumulator, go to M0.
- M0: `sel_cte`=0101, acc += cte·x0.
- M1: `sel_cte`=0110, acc += cte·x1.
- M2: `sel_cte`=0111, acc += cte·x2.
- M3: `sel_cte`=0001, acc += cte·y1.
- M4: `sel_cte`=0010, acc += cte·y2. Then go to OUT.
- OUT: `sel_cte`=0000. Compute r = acc >>> frac_bits, arithmetic shift, truncation toward −∞. Saturate r to [−2^(cant_bits−1), 2^(cant_bits−1)−1]. Register r into `y_out`. Shift delay lines: x2←x1, x1←x0, y2←y1, y1←saturated r. Pulse `done`. Go to IDLE.
- Arithmetic: products are full 2·cant_bits signed. Accumulator is 2·cant_bits+3 bits and never wraps. Shift and saturation apply only once, in OUT.
- `start` outside IDLE is ignored and not queued. `start` held high starts a new sample on every IDLE cycle.
- Select codes 0000 (unity) and 0011/0100/1xxx are never issued during M-states.

## Timing
- Reset values: `y_out`=0, `done`=0, `busy`=0, `sel_cte`=0000. Accumulator, x0–x2 and y1–y2 are 0. State is IDLE.
- `start` accepted at edge E0. M0..M4 accumulate at edges E1..E5. OUT registers `y_out` and `done` at E6.
- `done` is high for exactly the cycle after E6. `busy` is high E0→E6, low when `done` is high.
- Throughput: one sample per 7 cycles, since IDLE lasts at least one cycle between samples.
- `sel_cte` is a registered state decode: stable the whole M-cycle and glitch-free at the edge.
- `reset` in any state: return to IDLE next edge, no `done`, delay lines and `y_out` cleared. A partial result is discarded.
- `reset` and `start` in the same cycle: reset wins.

## Test plan
- Reset: assert `reset` mid-M2 → next cycle `done`=0, `busy`=0, `y_out`=0, `sel_cte`=0000.
- Coefficient sequence: one `start` → `sel_cte` = 0101, 0110, 0111, 0001, 0010 on five consecutive cycles. `done` exactly 6 cycles after start edge.
- Impulse with high-pass ROM: x=0x0004000 then zeros → y[0]=0x0003FDF, y[1]=0x1FFFFBE (−66). Continue 50 samples bit-exact against a fixed-point golden model.
- Saturation: from reset, x=0x0FFFFFF then x=0x1000000 → y[0]=0x0FF7BFF, y[1]=0x1000000 (clamped, not wrapped). Mirror the case for positive clamp to 0x0FFFFFF.
- Busy protection: pulse `start` again at E2 and E4 with different `x_in` → ignored. One `done`, result from the first sample only.
- Reset recovery: reset during M3 after several samples, then impulse 0x0004000 → y=0x0003FDF (delay lines proven cleared). Back-to-back `start` held high → `done` every 7 cycles.
